// File: rtl/text_cursor_controller.sv
// -----------------------------------------------------------------------------
// text_cursor_controller
//
// Executes parsed terminal commands against a ROWS x COLS text RAM. Keeps the
// logical cursor (row/col) and a circular top-line offset so scrolling only
// needs one line cleared instead of moving the whole buffer.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   command_ready     one-cycle pulse: command_type/pn1/pn2/pchar are valid
//   command_type      CommandsType (INPUT, IND, NEL, RI, CUU, CUD, CUF, CUB, CUP)
//   pn1, pn2, pchar   numeric parameters and character for INPUT
//   ram_we/addr/data  single-port text RAM write (addr = phys_row*COLS+col)
//   cursor_row/col    logical cursor position
//   top_line          physical row displayed as screen row 0
//   busy              FSM not idle or command FIFO not empty
//   overflow          sticky: a command arrived with the FIFO full
//   dbg_state         current FSM state (state_t encoding)
//
// Handshake: command_ready has no back-pressure. A pulse is accepted when the
// FIFO has room, or when it is full but an entry is popped in the same cycle;
// otherwise the command is dropped and overflow is set until reset.
// -----------------------------------------------------------------------------
package text_cursor_pkg;
  typedef enum logic [3:0] {
    INPUT = 4'd0, IND = 4'd1, NEL = 4'd2, RI  = 4'd3, CUU = 4'd4,
    CUD   = 4'd5, CUF = 4'd6, CUB = 4'd7, CUP = 4'd8
  } CommandsType;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_CLEAR = 2'd2} state_t;
endpackage

module text_cursor_controller
  import text_cursor_pkg::*;
#(
  parameter int ROWS       = 30,
  parameter int COLS       = 80,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              command_ready,
  input  CommandsType       command_type,
  input  logic [7:0]        pn1,
  input  logic [7:0]        pn2,
  input  logic [7:0]        pchar,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic [4:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic [4:0]        top_line,
  output logic              busy,
  output logic              overflow,
  output logic [1:0]        dbg_state
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]        ROW_MAX  = 5'(ROWS - 1);
  localparam logic [6:0]        COL_MAX  = 7'(COLS - 1);
  localparam logic [8:0]        ROW_MAX9 = 9'(ROWS - 1);
  localparam logic [8:0]        COL_MAX9 = 9'(COLS - 1);
  localparam logic [5:0]        ROWS6    = 6'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  // ---------------- command FIFO ----------------
  logic [27:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic             w_empty, w_full, w_pop, w_push;
  logic [27:0]      w_head;

  state_t r_state, w_state_n;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push  = command_ready && (!w_full || w_pop);
  assign w_head  = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {command_type, pn1, pn2, pchar};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (command_ready && !w_push) r_overflow <= 1'b1;
    end
  end

  // ---------------- command register and cursor state ----------------
  CommandsType r_cmd;
  logic [7:0]  r_pn1, r_pn2, r_pchar;
  logic [4:0]  r_row, r_top, r_clr_row;
  logic [6:0]  r_col, r_clr_k;

  // Step/position arithmetic is 9-bit so large parameters never wrap.
  logic [8:0] w_n9, w_row9, w_col9, w_rsum, w_csum, w_p1m, w_p2m;
  logic [4:0] w_cuu, w_cud, w_cup_row;
  logic [6:0] w_cuf, w_cub, w_cup_col;

  assign w_n9   = (r_pn1 == 8'd0) ? 9'd1 : {1'b0, r_pn1};
  assign w_row9 = {4'd0, r_row};
  assign w_col9 = {2'd0, r_col};
  assign w_rsum = w_row9 + w_n9;
  assign w_csum = w_col9 + w_n9;
  assign w_p1m  = (r_pn1 == 8'd0) ? 9'd0 : {1'b0, r_pn1} - 9'd1;
  assign w_p2m  = (r_pn2 == 8'd0) ? 9'd0 : {1'b0, r_pn2} - 9'd1;

  assign w_cuu     = (w_n9 >= w_row9)    ? 5'd0    : 5'(w_row9 - w_n9);
  assign w_cud     = (w_rsum >= ROW_MAX9) ? ROW_MAX : 5'(w_rsum);
  assign w_cub     = (w_n9 >= w_col9)    ? 7'd0    : 7'(w_col9 - w_n9);
  assign w_cuf     = (w_csum >= COL_MAX9) ? COL_MAX : 7'(w_csum);
  assign w_cup_row = (w_p1m >= ROW_MAX9)  ? ROW_MAX : 5'(w_p1m);
  assign w_cup_col = (w_p2m >= COL_MAX9)  ? COL_MAX : 7'(w_p2m);

  // Physical row of the cursor in the circular buffer.
  logic [5:0]        w_phys_sum;
  logic [4:0]        w_phys;
  logic [ADDR_W-1:0] w_exec_addr, w_clear_addr;

  assign w_phys_sum   = {1'b0, r_top} + {1'b0, r_row};
  assign w_phys       = (w_phys_sum >= ROWS6) ? 5'(w_phys_sum - ROWS6) : w_phys_sum[4:0];
  assign w_exec_addr  = ADDR_W'(w_phys) * COLS_A + ADDR_W'(r_col);
  assign w_clear_addr = ADDR_W'(r_clr_row) * COLS_A + ADDR_W'(r_clr_k);

  // ---------------- command execution ----------------
  logic [4:0] w_row_n, w_top_n, w_clr_row_n;
  logic [6:0] w_col_n;
  logic       w_scroll, w_exec_we, w_lf, w_printable;

  assign w_printable = (r_pchar >= 8'h20) && (r_pchar <= 8'h7E);

  always_comb begin
    w_row_n     = r_row;
    w_col_n     = r_col;
    w_top_n     = r_top;
    w_clr_row_n = r_clr_row;
    w_scroll    = 1'b0;
    w_exec_we   = 1'b0;
    w_lf        = 1'b0;
    case (r_cmd)
      INPUT: begin
        if (w_printable) begin
          w_exec_we = 1'b1;
          if (r_col < COL_MAX) w_col_n = r_col + 7'd1;
          else begin
            w_col_n = 7'd0;
            w_lf    = 1'b1;
          end
        end else if (r_pchar == 8'h0D) w_col_n = 7'd0;
        else if (r_pchar == 8'h0A) w_lf = 1'b1;
        else if (r_pchar == 8'h08) w_col_n = (r_col == 7'd0) ? 7'd0 : r_col - 7'd1;
      end
      IND: w_lf = 1'b1;
      NEL: begin
        w_col_n = 7'd0;
        w_lf    = 1'b1;
      end
      RI: begin
        if (r_row != 5'd0) w_row_n = r_row - 5'd1;
        else begin
          // The new top physical row is the one that scrolls into view.
          w_top_n     = (r_top == 5'd0) ? ROW_MAX : r_top - 5'd1;
          w_clr_row_n = w_top_n;
          w_scroll    = 1'b1;
        end
      end
      CUU: w_row_n = w_cuu;
      CUD: w_row_n = w_cud;
      CUF: w_col_n = w_cuf;
      CUB: w_col_n = w_cub;
      CUP: begin
        w_row_n = w_cup_row;
        w_col_n = w_cup_col;
      end
      default: ;
    endcase
    if (w_lf) begin
      if (r_row < ROW_MAX) w_row_n = r_row + 5'd1;
      else begin
        // The old top row becomes the new bottom row and must be blanked.
        w_top_n     = (r_top == ROW_MAX) ? 5'd0 : r_top + 5'd1;
        w_clr_row_n = r_top;
        w_scroll    = 1'b1;
      end
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_n = S_EXEC;
      S_EXEC:  w_state_n = w_scroll ? S_CLEAR : S_IDLE;
      S_CLEAR: if (r_clr_k == COL_MAX) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cmd     <= INPUT;
      r_pn1     <= '0;
      r_pn2     <= '0;
      r_pchar   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_top     <= '0;
      r_clr_row <= '0;
      r_clr_k   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_pop) begin
        r_cmd   <= CommandsType'(w_head[27:24]);
        r_pn1   <= w_head[23:16];
        r_pn2   <= w_head[15:8];
        r_pchar <= w_head[7:0];
      end
      if (r_state == S_EXEC) begin
        r_row     <= w_row_n;
        r_col     <= w_col_n;
        r_top     <= w_top_n;
        r_clr_row <= w_clr_row_n;
        r_clr_k   <= 7'd0;
      end
      if (r_state == S_CLEAR) r_clr_k <= r_clr_k + 7'd1;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = 8'h00;
    if (r_state == S_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = w_clear_addr;
      ram_data = 8'h20;
    end else if (r_state == S_EXEC && w_exec_we) begin
      ram_we   = 1'b1;
      ram_addr = w_exec_addr;
      ram_data = r_pchar;
    end
  end

  assign cursor_row = r_row;
  assign cursor_col = r_col;
  assign top_line   = r_top;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;
endmodule
